// File: rtl/cpu_pkg.sv
// Shared CPU definitions used across decode and fetch.
package cpu_pkg;

    localparam int ADDR_W = 12;
    localparam int INST_W = 19;

    // Next-PC select; the call stack's popAddr feeds the POP leg of the fetch mux.
    typedef enum logic [1:0] {
        PC_PLUS1 = 2'd0,
        ID_NEW   = 2'd1,
        POP      = 2'd2,
        JMP      = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/call_stack_if.sv
// Decode-side handshake for the return-address stack.
interface call_stack_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 12
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              stall;
    logic              push;
    logic [ADDR_W-1:0] pushAddr;
    logic              pop;
    logic              clrErr;
    logic [ADDR_W-1:0] popAddr;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output stall, push, pushAddr, pop, clrErr,
        input  popAddr, empty, full, count, overflow, underflow
    );

    modport slave (
        input  stall, push, pushAddr, pop, clrErr,
        output popAddr, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/stack_mem.sv
// Return-address storage: one write port, one asynchronous read port, no reset.
module stack_mem #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [ADDR_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [ADDR_W-1:0]        o_rdata
);
    logic [ADDR_W-1:0] r_mem [DEPTH];

    // Write the addressed entry; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/call_stack.sv
// Circular return-address stack: oldest entry is dropped on overflow,
// top of stack is presented combinationally from registered state.
module call_stack #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic clk,
    input  logic rst,
    call_stack_if.slave bus
);
    import cpu_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  r_top;
    logic [PTR_W-1:0]  w_top_next;
    logic [PTR_W-1:0]  w_waddr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_we;
    logic              w_empty;
    logic              w_full;
    logic [ADDR_W-1:0] w_rd_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);

    // Decode push/pop into pointer, count, write and error-set actions.
    always_comb begin
        w_top_next   = r_top;
        w_count_next = r_count;
        w_waddr      = r_top;
        w_we         = 1'b0;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        if (!bus.stall) begin
            if (bus.push) begin
                if (bus.pop && !w_empty) begin
                    // Return followed by call: replace the top in place.
                    w_we    = 1'b1;
                    w_waddr = r_top;
                end else begin
                    w_top_next = r_top + PTR_W'(1);
                    w_waddr    = r_top + PTR_W'(1);
                    w_we       = 1'b1;
                    if (w_full) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_count_next = r_count + CNT_W'(1);
                    end
                end
            end else if (bus.pop) begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_top_next   = r_top - PTR_W'(1);
                    w_count_next = r_count - CNT_W'(1);
                end
            end
        end
    end

    // Pointer, count and sticky flags; a new error beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_top       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_top       <= w_top_next;
            r_count     <= w_count_next;
            r_overflow  <= w_ovf_set | (r_overflow  & ~bus.clrErr);
            r_underflow <= w_unf_set | (r_underflow & ~bus.clrErr);
        end
    end

    // Writes are suppressed during reset so a push in that cycle is discarded.
    stack_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we & rst),
        .i_waddr (w_waddr),
        .i_wdata (bus.pushAddr),
        .i_raddr (r_top),
        .o_rdata (w_rd_data)
    );

    assign bus.popAddr   = w_empty ? '0 : w_rd_data;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: directed vector table, a push+pop same-cycle sequence,
// then a randomized phase checked against a queue-based stack model.
module tb_call_stack;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    call_stack_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    call_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic              rstn;
        logic              stall;
        logic              push;
        logic              pop;
        logic              clr;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] e_pa;
        int                e_cnt;
        logic              e_ovf;
        logic              e_unf;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] pa;
        int                cnt;
        logic              ovf;
        logic              unf;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: a plain queue, newest at the back.
    logic [ADDR_W-1:0] model[$];
    logic              m_ovf = 1'b0;
    logic              m_unf = 1'b0;

    function automatic vec_t mk(logic rstn, logic stall, logic push, logic pop, logic clr,
                                int addr, int e_pa, int e_cnt, logic e_ovf, logic e_unf);
        vec_t v;
        v.rstn = rstn; v.stall = stall; v.push = push; v.pop = pop; v.clr = clr;
        v.addr = ADDR_W'(addr); v.e_pa = ADDR_W'(e_pa); v.e_cnt = e_cnt;
        v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    task automatic check(string nm, int idx, int act, int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", nm, idx, act, req);
        end
    endtask

    task automatic check_state(string tag, int idx, exp_t e);
        check({tag, "_popAddr"},   idx, int'(bus.popAddr),   int'(e.pa));
        check({tag, "_count"},     idx, int'(bus.count),     e.cnt);
        check({tag, "_empty"},     idx, int'(bus.empty),     (e.cnt == 0) ? 1 : 0);
        check({tag, "_full"},      idx, int'(bus.full),      (e.cnt == DEPTH) ? 1 : 0);
        check({tag, "_overflow"},  idx, int'(bus.overflow),  int'(e.ovf));
        check({tag, "_underflow"}, idx, int'(bus.underflow), int'(e.unf));
    endtask

    task automatic drive(logic rstn, logic stall, logic push, logic pop, logic clr, logic [ADDR_W-1:0] addr);
        rst          = rstn;
        bus.stall    = stall;
        bus.push     = push;
        bus.pop      = pop;
        bus.clrErr   = clr;
        bus.pushAddr = addr;
    endtask

    // Advance the model by one edge with the given inputs.
    task automatic model_step(logic rstn, logic stall, logic push, logic pop, logic clr, logic [ADDR_W-1:0] addr);
        logic os, us;
        os = 1'b0; us = 1'b0;
        if (!rstn) begin
            model.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (!stall) begin
                if (push && pop && model.size() != 0) begin
                    model[model.size()-1] = addr;
                end else if (push) begin
                    if (model.size() == DEPTH) begin
                        void'(model.pop_front());
                        os = 1'b1;
                    end
                    model.push_back(addr);
                end else if (pop) begin
                    if (model.size() == 0) us = 1'b1;
                    else void'(model.pop_back());
                end
            end
            m_ovf = os | (m_ovf & ~clr);
            m_unf = us | (m_unf & ~clr);
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.pa  = (model.size() == 0) ? '0 : model[model.size()-1];
        e.cnt = model.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    initial begin
        exp_t e;
        logic [ADDR_W-1:0] prev_pa;

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;

        // {rstn, stall, push, pop, clr, addr, exp popAddr, exp count, exp ovf, exp unf}
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h010, 'h010, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h020, 'h020, 2, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h030, 'h030, 3, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 'h000, 'h020, 2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 'h000, 'h010, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 'h000, 'h000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 'h000, 'h000, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 'h000, 'h000, 0, 0, 0));
        for (int i = 1; i <= 9; i++)
            vecs.push_back(mk(1, 0, 1, 0, 0, 'h100 + i, 'h100 + i, (i > DEPTH) ? DEPTH : i, (i > DEPTH), 0));
        for (int i = 8; i >= 1; i--)
            vecs.push_back(mk(1, 0, 0, 1, 0, 'h000, (i > 1) ? ('h100 + i) : 0, i - 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 'h000, 'h000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h010, 'h010, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h020, 'h020, 2, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 'h0AA, 'h0AA, 2, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 'h055, 'h0AA, 2, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h033, 'h033, 3, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h044, 'h044, 4, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 'h077, 'h000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 'h000, 'h000, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 1, 'h000, 'h000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 'h0BB, 'h0BB, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 'h000, 'h000, 0, 0, 0));

        prev_pa = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rstn, vecs[i].stall, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].addr);
            e.pa = vecs[i].e_pa; e.cnt = vecs[i].e_cnt; e.ovf = vecs[i].e_ovf; e.unf = vecs[i].e_unf;
            exp_q.push_back(e);
            #1;
            // popAddr must reflect the current top, unaffected by this cycle's push/pop.
            check("vec_pre_popAddr", i, int'(bus.popAddr), int'(prev_pa));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            check_state("vec", i, e);
            $display("vec %0d rstn=%0b stall=%0b push=%0b pop=%0b clr=%0b addr=%03h -> popAddr=%03h count=%0d ovf=%0b unf=%0b",
                     i, vecs[i].rstn, vecs[i].stall, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].addr,
                     bus.popAddr, bus.count, bus.overflow, bus.underflow);
            prev_pa = e.pa;
        end

        // Hand sequence: count=2 with top 0x020, then push(0x0AA)+pop together.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010); @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h020); @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h0AA); #1;
        check("seq_swap_same_cycle_popAddr", 0, int'(bus.popAddr), 'h020);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("seq_swap_next_popAddr", 0, int'(bus.popAddr), 'h0AA);
        check("seq_swap_next_count", 0, int'(bus.count), 2);
        $display("seq swap popAddr=%03h count=%0d", bus.popAddr, bus.count);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0); @(posedge clk); #1;
        check("seq_swap_below_popAddr", 0, int'(bus.popAddr), 'h010);
        $display("seq pop popAddr=%03h count=%0d", bus.popAddr, bus.count);

        // Randomized phase: resync via reset, then scoreboard against the model.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0); @(posedge clk); #1;
        model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 400; i++) begin
            logic rr, ss, pu, po, cl;
            logic [ADDR_W-1:0] ad;
            rr = ($urandom_range(0, 99) != 0);
            ss = ($urandom_range(0, 9) == 0);
            pu = ($urandom_range(0, 99) < ((i % 100) < 50 ? 60 : 35));
            po = ($urandom_range(0, 99) < ((i % 100) < 50 ? 35 : 60));
            cl = ($urandom_range(0, 19) == 0);
            ad = ADDR_W'($urandom);
            drive(rr, ss, pu, po, cl, ad);
            model_step(rr, ss, pu, po, cl, ad);
            exp_q.push_back(model_exp());
            @(posedge clk); #1;
            e = exp_q.pop_front();
            check_state("rnd", i, e);
            $display("rnd %0d rstn=%0b stall=%0b push=%0b pop=%0b clr=%0b addr=%03h -> popAddr=%03h count=%0d ovf=%0b unf=%0b",
                     i, rr, ss, pu, po, cl, ad, bus.popAddr, bus.count, bus.overflow, bus.underflow);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
